// File: rtl/kbd_input_controller.sv
// kbd_input_controller: turns raw PS/2 Set-2 bytes into a decimal word for
// the CPU's keyboard IN instruction. Break (F0) and extended (E0) sequences
// are filtered out, make codes go through an external registered decoder,
// and digits accumulate until Enter completes the entry.
module kbd_input_controller #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_valid,
  input  logic [7:0]        scan_byte,
  output logic [7:0]        dec_scan,
  input  logic [7:0]        dec_ascii,
  input  logic              in_req,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  input  logic              in_ack,
  output logic              busy,
  output logic [3:0]        digit_cnt,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    DEC_WAIT = 3'd2,
    EVAL     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  state_t            state_reg, state_next;
  logic [7:0]        dec_scan_reg, dec_scan_next;
  logic              in_valid_reg, in_valid_next;
  logic [DATA_W-1:0] in_data_reg, in_data_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [3:0]        digit_cnt_reg, digit_cnt_next;
  logic              overrun_reg, overrun_next;
  logic              brk_flag_reg, brk_flag_next;
  logic              ext_flag_reg, ext_flag_next;

  logic              is_digit;
  logic [7:0]        digit_val;

  assign is_digit  = (dec_ascii >= 8'h30) && (dec_ascii <= 8'h39);
  assign digit_val = dec_ascii - 8'h30;

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      dec_scan_reg  <= 8'h00;
      in_valid_reg  <= 1'b0;
      in_data_reg   <= '0;
      acc_reg       <= '0;
      digit_cnt_reg <= 4'd0;
      overrun_reg   <= 1'b0;
      brk_flag_reg  <= 1'b0;
      ext_flag_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dec_scan_reg  <= dec_scan_next;
      in_valid_reg  <= in_valid_next;
      in_data_reg   <= in_data_next;
      acc_reg       <= acc_next;
      digit_cnt_reg <= digit_cnt_next;
      overrun_reg   <= overrun_next;
      brk_flag_reg  <= brk_flag_next;
      ext_flag_reg  <= ext_flag_next;
    end
  end

  // Next-state and datapath updates; every register holds unless changed.
  always_comb begin
    state_next     = state_reg;
    dec_scan_next  = dec_scan_reg;
    in_valid_next  = in_valid_reg;
    in_data_next   = in_data_reg;
    acc_next       = acc_reg;
    digit_cnt_next = digit_cnt_reg;
    overrun_next   = overrun_reg;
    brk_flag_next  = brk_flag_reg;
    ext_flag_next  = ext_flag_reg;

    case (state_reg)
      IDLE: begin
        // Bytes arriving here (including the accept cycle) are simply ignored.
        if (in_req) begin
          state_next     = WAIT_KEY;
          acc_next       = '0;
          digit_cnt_next = 4'd0;
          brk_flag_next  = 1'b0;
          ext_flag_next  = 1'b0;
          overrun_next   = 1'b0;
        end
      end

      WAIT_KEY: begin
        if (scan_valid) begin
          if (scan_byte == BYTE_BREAK) begin
            brk_flag_next = 1'b1;
          end else if (scan_byte == BYTE_EXT) begin
            ext_flag_next = 1'b1;
          end else if (brk_flag_reg || ext_flag_reg) begin
            // Release code or extended key (incl. E0 F0 xx): swallow it.
            brk_flag_next = 1'b0;
            ext_flag_next = 1'b0;
          end else begin
            dec_scan_next = scan_byte;
            state_next    = DEC_WAIT;
          end
        end
      end

      DEC_WAIT: begin
        // Decoder registers dec_scan during this cycle.
        if (scan_valid) overrun_next = 1'b1;
        state_next = EVAL;
      end

      EVAL: begin
        if (scan_valid) overrun_next = 1'b1;
        state_next = WAIT_KEY;
        if (is_digit) begin
          if (digit_cnt_reg < 4'(MAX_DIGITS)) begin
            acc_next       = acc_reg * DATA_W'(10) + DATA_W'(digit_val);
            digit_cnt_next = digit_cnt_reg + 4'd1;
          end
        end else if ((dec_ascii == ASCII_CR) && (digit_cnt_reg != 4'd0)) begin
          in_data_next  = acc_reg;
          in_valid_next = 1'b1;
          state_next    = DONE;
        end
      end

      DONE: begin
        if (scan_valid) overrun_next = 1'b1;
        if (in_ack) begin
          in_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign dec_scan  = dec_scan_reg;
  assign in_valid  = in_valid_reg;
  assign in_data   = in_data_reg;
  assign busy      = (state_reg != IDLE);
  assign digit_cnt = digit_cnt_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_kbd_input_controller.sv
// tb_kbd_input_controller: directed bench for the keyboard IN controller.
// A 32-bit and an 8-bit instance share all stimulus; each has its own
// registered Set-2 decoder model.
module tb_kbd_input_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_valid = 1'b0;
  logic [7:0]  scan_byte = 8'h00;
  logic        in_req = 1'b0;
  logic        in_ack = 1'b0;

  logic [7:0]  dec_scan32, dec_ascii32;
  logic        in_valid32, busy32, overrun32;
  logic [31:0] in_data32;
  logic [3:0]  digit_cnt32;

  logic [7:0]  dec_scan8, dec_ascii8;
  logic        in_valid8, busy8, overrun8;
  logic [7:0]  in_data8;
  logic [3:0]  digit_cnt8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  kbd_input_controller #(.DATA_W(32), .MAX_DIGITS(9)) u32 (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .dec_scan(dec_scan32), .dec_ascii(dec_ascii32), .in_req(in_req),
    .in_valid(in_valid32), .in_data(in_data32), .in_ack(in_ack),
    .busy(busy32), .digit_cnt(digit_cnt32), .overrun(overrun32)
  );

  kbd_input_controller #(.DATA_W(8), .MAX_DIGITS(9)) u8 (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .dec_scan(dec_scan8), .dec_ascii(dec_ascii8), .in_req(in_req),
    .in_valid(in_valid8), .in_data(in_data8), .in_ack(in_ack),
    .busy(busy8), .digit_cnt(digit_cnt8), .overrun(overrun8)
  );

  // Set-2 make code to ASCII for the keys used here.
  function automatic logic [7:0] scan2ascii(input logic [7:0] sc);
    case (sc)
      8'h45: return 8'h30;
      8'h16: return 8'h31;
      8'h1E: return 8'h32;
      8'h26: return 8'h33;
      8'h25: return 8'h34;
      8'h2E: return 8'h35;
      8'h36: return 8'h36;
      8'h3D: return 8'h37;
      8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  // Registered decoder models: valid one cycle after dec_scan changes.
  always @(posedge clk) begin
    dec_ascii32 <= scan2ascii(dec_scan32);
    dec_ascii8  <= scan2ascii(dec_scan8);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One byte strobe followed by enough idle cycles to return to WAIT_KEY.
  task automatic send(input logic [7:0] b);
    $display("tx scan=%02h", b);
    scan_valid = 1'b1;
    scan_byte  = b;
    tick;
    scan_valid = 1'b0;
    repeat (3) tick;
  endtask

  task automatic start;
    $display("tx in_req");
    in_req = 1'b1;
    tick;
    in_req = 1'b0;
  endtask

  task automatic ack;
    $display("tx in_ack");
    in_ack = 1'b1;
    tick;
    in_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) tick;
    chk("rst_in_valid", 32'(in_valid32), 32'd0);
    chk("rst_in_data", in_data32, 32'd0);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_dec_scan", 32'(dec_scan32), 32'h00);
    chk("rst_digit_cnt", 32'(digit_cnt32), 32'd0);
    chk("rst_overrun", 32'(overrun32), 32'd0);
    rst_n = 1'b1;
    tick;

    // in_ack while idle does nothing
    ack;
    chk("idle_ack_busy", 32'(busy32), 32'd0);

    // "123" with break codes interleaved, exact Enter latency
    start;
    chk("accept_busy", 32'(busy32), 32'd1);
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h26); send(8'hF0); send(8'h26);
    chk("123_digit_cnt", 32'(digit_cnt32), 32'd3);
    $display("tx scan=5a");
    scan_valid = 1'b1;
    scan_byte  = 8'h5A;
    tick;
    scan_valid = 1'b0;
    chk("123_valid_n1", 32'(in_valid32), 32'd0);
    tick;
    chk("123_valid_n2", 32'(in_valid32), 32'd0);
    tick;
    chk("123_valid_n3", 32'(in_valid32), 32'd1);
    chk("123_data", in_data32, 32'd123);
    tick;
    chk("123_valid_hold", 32'(in_valid32), 32'd1);
    ack;
    chk("123_ack_valid", 32'(in_valid32), 32'd0);
    chk("123_ack_busy", 32'(busy32), 32'd0);
    chk("123_ack_data", in_data32, 32'd123);

    // Keypad Enter (E0 5A) ignored as make and break
    start;
    send(8'hE0); send(8'h5A); send(8'h45); send(8'hF0); send(8'h45);
    send(8'hE0); send(8'hF0); send(8'h5A); send(8'h5A);
    chk("ext_valid", 32'(in_valid32), 32'd1);
    chk("ext_data", in_data32, 32'd0);
    chk("ext_digit_cnt", 32'(digit_cnt32), 32'd1);
    ack;

    // Enter with no digits is ignored; byte during DEC_WAIT is dropped
    start;
    send(8'h5A);
    repeat (3) tick;
    chk("empty_valid", 32'(in_valid32), 32'd0);
    chk("empty_busy", 32'(busy32), 32'd1);
    $display("tx scan=3d");
    scan_valid = 1'b1;
    scan_byte  = 8'h3D;
    tick;
    $display("tx scan=16 (during decode)");
    scan_byte = 8'h16;
    tick;
    scan_valid = 1'b0;
    chk("drop_overrun", 32'(overrun32), 32'd1);
    repeat (2) tick;
    chk("drop_digit_cnt", 32'(digit_cnt32), 32'd1);
    send(8'h5A);
    chk("drop_valid", 32'(in_valid32), 32'd1);
    chk("drop_data", in_data32, 32'd7);
    ack;
    chk("overrun_sticky", 32'(overrun32), 32'd1);
    start;
    chk("overrun_cleared", 32'(overrun32), 32'd0);

    // Eleven nines: only MAX_DIGITS accepted
    repeat (11) send(8'h46);
    chk("nines_digit_cnt", 32'(digit_cnt32), 32'd9);
    send(8'h5A);
    chk("nines_data", in_data32, 32'd999999999);
    chk("nines_valid", 32'(in_valid32), 32'd1);
    ack;

    // "300": 8-bit instance wraps mod 256
    start;
    send(8'h26); send(8'h45); send(8'h45); send(8'h5A);
    chk("300_data32", in_data32, 32'd300);
    chk("300_valid8", 32'(in_valid8), 32'd1);
    chk("300_data8", 32'(in_data8), 32'd44);
    ack;

    // Asynchronous reset in the middle of DEC_WAIT
    start;
    $display("tx scan=16");
    scan_valid = 1'b1;
    scan_byte  = 8'h16;
    tick;
    scan_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy32), 32'd1);
    chk("pre_rst_dec_scan", 32'(dec_scan32), 32'h16);
    #2;
    $display("tx rst_n=0 (mid-cycle)");
    rst_n = 1'b0;
    #1;
    chk("arst_in_valid", 32'(in_valid32), 32'd0);
    chk("arst_busy", 32'(busy32), 32'd0);
    chk("arst_dec_scan", 32'(dec_scan32), 32'h00);
    chk("arst_digit_cnt", 32'(digit_cnt32), 32'd0);
    chk("arst_in_data", in_data32, 32'd0);
    #3;
    rst_n = 1'b1;
    tick;
    start;
    send(8'h3E); send(8'h5A);
    chk("restart_valid", 32'(in_valid32), 32'd1);
    chk("restart_data", in_data32, 32'd8);
    ack;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_input_controller.md
Name: kbd_input_controller

Overview:
- Sequences the PS/2 scan-code decoder for the processor's keyboard IN instruction.
- Consumes raw Set-2 bytes from the PS/2 receiver and filters break (F0) and extended (E0) sequences.
- Feeds each make code to the decoder and accumulates decimal digits into an unsigned word.
- Returns the word to the CPU through a req/valid/ack handshake when Enter is pressed.

Parameters:
- DATA_W, 32, width of the accumulated value and of in_data.
- MAX_DIGITS, 9, maximum digits accepted per entry; further digits are ignored.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- scan_valid  input  1  one-cycle strobe: scan_byte holds a new byte from the PS/2 receiver.
- scan_byte  input  8  raw PS/2 Set-2 byte.
- dec_scan  output  8  registered scan code driven to the decoder.
- dec_ascii  input  8  decoder output; registered, valid 1 cycle after dec_scan changes.
- in_req  input  1  CPU requests a keyboard value; level, sampled in IDLE.
- in_valid  output  1  in_data holds a completed entry.
- in_data  output  DATA_W  entered value.
- in_ack  input  1  CPU consumed in_data.
- busy  output  1  high in every state except IDLE.
- digit_cnt  output  4  digits accepted in the current entry (for display).
- overrun  output  1  sticky: a scan byte was dropped while decoding.

Behaviour:
- Reset (async, rst_n=0): state IDLE; dec_scan=8'h00; in_valid=0; in_data=0; digit_cnt=0; overrun=0; brk_flag=0; ext_flag=0; internal accumulator=0.
- IDLE: scan bytes are ignored.
  - in_req=1 -> WAIT_KEY; clear accumulator, digit_cnt, brk_flag, ext_flag and overrun.
- WAIT_KEY, on scan_valid:
  - byte F0 -> brk_flag=1, stay.
  - byte E0 -> ext_flag=1, stay.
  - otherwise, if brk_flag or ext_flag is set -> clear both, discard the byte, stay. This covers both release codes and extended keys, including E0 F0 xx.
  - otherwise -> dec_scan<=byte, go to DEC_WAIT.
- DEC_WAIT: one cycle, while the decoder registers. Then -> EVAL.
- EVAL: examine dec_ascii, then act:
  - 8'h30..8'h39 with digit_cnt<MAX_DIGITS -> acc = acc*10 + (dec_ascii-8'h30), truncated mod 2^DATA_W; digit_cnt+1; -> WAIT_KEY.
  - digit with digit_cnt==MAX_DIGITS -> no change; -> WAIT_KEY.
  - 8'h0D with digit_cnt>0 -> in_data<=acc, in_valid<=1; -> DONE.
  - 8'h0D with digit_cnt==0 -> ignored; -> WAIT_KEY.
  - any other value -> ignored; -> WAIT_KEY.
- Key latency: the Enter byte strobed in cycle N gives in_valid=1 from cycle N+3.
- DONE: in_valid and in_data are held stable until in_ack=1.
  - On in_ack: in_valid<=0, -> IDLE. in_data keeps its last value.
  - in_ack outside DONE has no effect.
- Scan bytes strobed in DEC_WAIT, EVAL or DONE are dropped and set overrun=1.
- F0/E0 flags persist across DEC_WAIT/EVAL only in the sense that they cannot be set there.
- scan_valid coincident with the WAIT_KEY entry cycle (the in_req accept) is dropped without setting overrun.
- in_req deasserting mid-entry does not abort; the entry completes.
- rst_n low in any state returns all outputs to their reset values immediately.

Test Plan:
- Reset mid-DEC_WAIT -> in_valid=0, busy=0, dec_scan=00, digit_cnt=0 asynchronously. After release, in_req restarts cleanly.
- in_req, then bytes 16,F0,16,1E,F0,1E,26,F0,26,5A -> in_valid=1 with in_data=123 exactly 3 cycles after the 5A strobe. in_ack drops in_valid next cycle, state IDLE.
- in_req, bytes E0,5A,45,F0,45,E0,F0,5A,5A -> keypad Enter ignored both as make and break. Result in_data=0 with digit_cnt=1.
- in_req, Enter (5A) alone -> no in_valid, busy stays 1. Then 3D,5A -> in_data=7.
- Eleven '9' keys then Enter -> digit_cnt=9, in_data=999999999. With DATA_W=8, "300" then Enter -> in_data=300 mod 256=44.
- Byte strobed 1 cycle after a digit byte -> dropped, overrun=1, result unaffected. overrun clears on the next in_req accept.
